// File: rtl/word_align_ctrl.sv
// Link-training controller for the 64-bit receive path: drives aligner init, hunts for the
// periodic sync word, declares link-up and forwards payload with sync slots stripped.
module word_align_ctrl #(
    parameter int unsigned INIT_CYC  = 8,
    parameter int unsigned SEARCH_TO = 4096,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned LOSS_CNT  = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        ALIGNED,
    input  logic        DIPUSH,
    input  logic [63:0] DIN,
    output logic        PHY_INIT,
    output logic        LINK_UP,
    output logic        DOPUSH,
    output logic [63:0] DOUT,
    output logic [7:0]  RETRAIN_CNT,
    output logic [2:0]  STATE
);

    localparam logic [63:0] SYNC = 64'hF731_8CEF_137F_FEC8;
    localparam int unsigned IW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam int unsigned TW = $clog2(SEARCH_TO);
    localparam int unsigned FW = $clog2(FRAME_LEN);
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(LOSS_CNT + 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StInit   = 3'd1,
        StSearch = 3'd2,
        StVerify = 3'd3,
        StLink   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] init_q, init_d;
    logic [TW-1:0] to_q, to_d;
    logic [FW-1:0] idx_q, idx_d;
    logic [GW-1:0] good_q, good_d;
    logic [MW-1:0] miss_q, miss_d;
    logic [7:0]    retrain_q;
    logic          dopush_q;
    logic [63:0]   dout_q;
    logic          fwd;
    logic          retrain_inc;
    logic          is_sync;

    assign is_sync = (DIN == SYNC);

    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        to_d        = to_q;
        idx_d       = idx_q;
        good_d      = good_q;
        miss_d      = miss_q;
        fwd         = 1'b0;
        retrain_inc = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (EN) begin
                    state_d = StInit;
                    init_d  = '0;
                end
            end
            StInit: begin
                if (init_q == IW'(INIT_CYC - 1)) begin
                    state_d = StSearch;
                    to_d    = '0;
                end else begin
                    init_d = init_q + 1'b1;
                end
            end
            StSearch: begin
                // A sync push beats a coincident timeout.
                if (DIPUSH && ALIGNED && is_sync) begin
                    idx_d  = FW'(1);
                    good_d = GW'(1);
                    miss_d = '0;
                    state_d = (LOCK_CNT == 1) ? StLink : StVerify;
                end else if (to_q == TW'(SEARCH_TO - 1)) begin
                    state_d     = StInit;
                    init_d      = '0;
                    retrain_inc = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StVerify: begin
                if (!ALIGNED) begin
                    state_d     = StInit;
                    init_d      = '0;
                    retrain_inc = 1'b1;
                end else if (DIPUSH) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == '0) begin
                        if (is_sync) begin
                            good_d = good_q + 1'b1;
                            if (good_q == GW'(LOCK_CNT - 1)) begin
                                state_d = StLink;
                                miss_d  = '0;
                            end
                        end else begin
                            state_d     = StInit;
                            init_d      = '0;
                            retrain_inc = 1'b1;
                        end
                    end
                end
            end
            StLink: begin
                if (!ALIGNED) begin
                    state_d     = StInit;
                    init_d      = '0;
                    retrain_inc = 1'b1;
                end else if (DIPUSH) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q != '0) begin
                        fwd = 1'b1;
                    end else if (is_sync) begin
                        miss_d = '0;
                    end else if (miss_q == MW'(LOSS_CNT - 1)) begin
                        state_d     = StInit;
                        init_d      = '0;
                        retrain_inc = 1'b1;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Disable overrides everything, including any pending retrain or forward.
        if (!EN) begin
            state_d     = StIdle;
            fwd         = 1'b0;
            retrain_inc = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            init_q    <= '0;
            to_q      <= '0;
            idx_q     <= '0;
            good_q    <= '0;
            miss_q    <= '0;
            retrain_q <= '0;
            dopush_q  <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            to_q     <= to_d;
            idx_q    <= idx_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            dopush_q <= fwd;
            if (fwd) begin
                dout_q <= DIN;
            end
            if (retrain_inc && (retrain_q != 8'hFF)) begin
                retrain_q <= retrain_q + 8'd1;
            end
        end
    end

    assign STATE       = state_q;
    assign PHY_INIT    = (state_q == StIdle) || (state_q == StInit);
    assign LINK_UP     = (state_q == StLink);
    assign DOPUSH      = dopush_q;
    assign DOUT        = dout_q;
    assign RETRAIN_CNT = retrain_q;

endmodule

// File: doc/word_align_ctrl.md
# word_align_ctrl

Link-training controller for the 64-bit serial receive path. Sequences the word aligner: pulses its PHY_INIT, waits for ALIGNED, then checks that the sync word 64'hF731_8CEF_137F_FEC8 recurs at the frame period on the aligned stream. Declares link-up after enough consecutive good sync slots. Forwards payload words downstream with sync slots stripped, and retrains automatically on loss of sync or timeout.

## Interface
- INIT_CYC, 8: cycles PHY_INIT is held high per training attempt (≥1)
- SEARCH_TO, 4096: max cycles in SEARCH before retraining (≥2)
- FRAME_LEN, 256: pushes per frame; slot 0 carries the sync word (power of 2, ≥4)
- LOCK_CNT, 4: consecutive good sync slots needed for link-up, including the first found (≥1)
- LOSS_CNT, 3: consecutive missed sync slots in LINK that force retraining (≥1)
- CLK  in  1  clock; single clock domain
- RST  in  1  synchronous, active-high reset
- EN  in  1  training enable; low forces IDLE
- ALIGNED  in  1  aligner lock flag
- DIPUSH  in  1  aligned word valid (aligner DOPUSH)
- DIN  in  64  aligned word (aligner DOUT)
- PHY_INIT  out  1  aligner clear; high in IDLE and INIT
- LINK_UP  out  1  high in LINK state
- DOPUSH  out  1  registered payload valid
- DOUT  out  64  registered payload word
- RETRAIN_CNT  out  8  saturating count of entries to INIT from SEARCH, VERIFY or LINK
- STATE  out  3  IDLE=0, INIT=1, SEARCH=2, VERIFY=3, LINK=4

## Operation
- Reset values: STATE=IDLE, PHY_INIT=1, LINK_UP=0, DOPUSH=0, DOUT=0, RETRAIN_CNT=0. All internal counters are 0.
- EN=0 in any state: go to IDLE next cycle. This overrides every other transition.
- IDLE: when EN=1, go to INIT. IDLE→INIT does not count as a retrain.
- INIT: a cycle counter runs 0..INIT_CYC-1. After INIT_CYC cycles in INIT, go to SEARCH. DIPUSH is ignored.
- SEARCH: a timeout counter counts cycles from 0.
  - A push with ALIGNED=1 and DIN==SYNC goes to VERIFY. On that transition, frame index:=1 and good:=1.
  - If LOCK_CNT==1, that push goes directly to LINK instead.
  - If the timeout counter reaches SEARCH_TO-1 with no sync found, go to INIT and increment RETRAIN_CNT.
  - If a sync push coincides with the timeout, the sync push wins.
- Frame index (log2 FRAME_LEN bits):
  - Advances on every DIPUSH in VERIFY and LINK.
  - Wraps FRAME_LEN-1→0.
  - A push arriving at index 0 is the sync slot.
- VERIFY:
  - Sync slot with DIN==SYNC: good++. When good reaches LOCK_CNT, go to LINK with miss:=0.
  - Sync slot with DIN!=SYNC: go to INIT and increment RETRAIN_CNT.
  - DIN==SYNC at a non-zero index is treated as data and ignored.
- LINK:
  - Sync slot matching: miss:=0.
  - Sync slot not matching: miss++. When miss reaches LOSS_CNT, go to INIT and increment RETRAIN_CNT.
  - Non-sync pushes are forwarded as payload.
- ALIGNED=0 while in VERIFY or LINK: go to INIT and increment RETRAIN_CNT. This takes priority over same-cycle push handling.
- RETRAIN_CNT saturates at 255. Only RST clears it; EN=0 does not.
- Leaving LINK for any reason stops forwarding that same cycle. The push causing the exit is not forwarded.

## Timing
- DOPUSH/DOUT are registered, one cycle after the qualifying DIPUSH.
- DOUT holds its last value when DOPUSH=0.
- DOPUSH=1 only for pushes accepted while STATE==LINK at a non-zero index.
- Transitions take effect on the clock edge after the causing condition. PHY_INIT, LINK_UP and STATE are decoded from the registered state (no extra latency).
- PHY_INIT stays high exactly INIT_CYC cycles per INIT visit. Returning from IDLE gives IDLE duration plus INIT_CYC.
- Minimum time from EN rise to LINK_UP:
  - 1 cycle IDLE→INIT, plus INIT_CYC, plus SEARCH until the first sync,
  - plus (LOCK_CNT-1)·FRAME_LEN pushes.
- RST mid-operation: all outputs return to reset values on the next edge, and any in-flight DOPUSH is dropped.

## Test plan
Parameters for all scenarios: INIT_CYC=4, SEARCH_TO=64, FRAME_LEN=8, LOCK_CNT=3, LOSS_CNT=2.
- Clean lock: EN=1; ALIGNED=1 from cycle 6; push a sync every 8 words with payload 1..7 between → PHY_INIT high 5 cycles after reset release (IDLE+INIT). LINK_UP rises after the third sync. The payload of the next frame appears on DOUT one cycle after each push, and the sync is never forwarded. RETRAIN_CNT=0.
- Search timeout: ALIGNED=0 indefinitely → STATE cycles INIT(4)/SEARCH(64). RETRAIN_CNT increments every 68 cycles and saturates at 255.
- Verify failure: sync found, then slot 0 of the second frame carries 0 → STATE INIT next edge; RETRAIN_CNT=1; LINK_UP never asserted.
- Loss in LINK: in LINK, one corrupted sync then a good sync → stays in LINK with miss reset. Two consecutive corrupted syncs → INIT on the second slot, LINK_UP falls, and that push is not forwarded.
- ALIGNED drop plus simultaneous push: in LINK, ALIGNED=0 in the same cycle as a payload push → INIT, DOPUSH stays 0.
- EN/RST mid-LINK: EN=0 → IDLE next edge, PHY_INIT=1, RETRAIN_CNT unchanged. RST=1 → all outputs return to reset values, including RETRAIN_CNT=0.
